// File: rtl/pc_fetch_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_ctrl_pkg                                               |
// | Purpose  : Shared BIP fetch-sequencer defaults, state encoding and helper  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package pc_fetch_ctrl_pkg;

  localparam int c_default_length   = 11;
  localparam int c_default_opcode_w = 5;
  localparam int c_default_cnt_w    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HALT  = 3'd3,
    ST_STEP  = 3'd4
  } fetch_state_t;

  // STEP counts as busy for the debug unit even though it does not advance the counter.
  function automatic logic is_busy(input fetch_state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_STEP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_ctrl_if                                                |
// | Purpose  : Fetch-controller bundle to incrementer, ROM and debug unit.     |
// |            Step ports exist only when PC_STEP_EN is defined.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_ctrl_if #(
  parameter int LENGTH   = 11,
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
);
  logic                start;
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic [LENGTH-1:0]   new_pc;
  logic [LENGTH-1:0]   old_pc;
  logic                value;
  logic                fetch_req;
  logic                busy;
  logic                halted;
  logic [CNT_W-1:0]    cycle_count;
`ifdef PC_STEP_EN
  logic                step_mode;
  logic                step;

  modport master (
    input  start, instr_valid, opcode, new_pc, step_mode, step,
    output old_pc, value, fetch_req, busy, halted, cycle_count
  );
  modport slave (
    output start, instr_valid, opcode, new_pc, step_mode, step,
    input  old_pc, value, fetch_req, busy, halted, cycle_count
  );
`else
  modport master (
    input  start, instr_valid, opcode, new_pc,
    output old_pc, value, fetch_req, busy, halted, cycle_count
  );
  modport slave (
    output start, instr_valid, opcode, new_pc,
    input  old_pc, value, fetch_req, busy, halted, cycle_count
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_ctrl                                                   |
// | Purpose  : BIP program-counter owner and fetch sequencer.                  |
// |            Optional single-step mode enabled by macro PC_STEP_EN.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                  LENGTH      = c_default_length,
  parameter int                  OPCODE_W    = c_default_opcode_w,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = '0,
  parameter int                  CNT_W       = c_default_cnt_w
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic              w_restart;
  logic              w_commit;
  logic              w_value;
  logic              w_counting;
  logic [LENGTH-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fetch_req;
  logic              r_busy;
  logic              r_halted;

  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_commit  = 1'b0;
    w_value   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_next    = ST_FETCH;
          w_restart = 1'b1;
        end
      end
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT: begin
        // start is deliberately not looked at here: a commit always wins.
        if (bus.instr_valid) begin
          if (bus.opcode == HALT_OPCODE) begin
            w_next = ST_HALT;
          end else begin
            w_value  = 1'b1;
            w_commit = 1'b1;
`ifdef PC_STEP_EN
            w_next   = bus.step_mode ? ST_STEP : ST_FETCH;
`else
            w_next   = ST_FETCH;
`endif
          end
        end
      end
`ifdef PC_STEP_EN
      ST_STEP: begin
        if (bus.step || !bus.step_mode) begin
          w_next = ST_FETCH;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_counting = (r_state == ST_FETCH) || (r_state == ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_fetch_req <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_pc <= '0;
      end else if (w_commit) begin
        r_pc <= bus.new_pc;
      end
      if (w_restart) begin
        r_cnt <= '0;
      end else if (w_counting && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Status flags are decoded from the next state so they line up with r_state.
      r_fetch_req <= (w_next == ST_FETCH);
      r_busy      <= is_busy(w_next);
      r_halted    <= (w_next == ST_HALT);
    end
  end

  assign bus.old_pc      = r_pc;
  assign bus.value       = w_value;
  assign bus.fetch_req   = r_fetch_req;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.cycle_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_ctrl                                                |
// | Purpose  : Directed self-checking bench for pc_fetch_ctrl (PC_STEP_EN opt) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_ctrl;

  localparam int LENGTH   = 11;
  localparam int OPCODE_W = 5;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n_val = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.LENGTH(LENGTH), .OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) bus ();
  pc_fetch_ctrl_if #(.LENGTH(LENGTH), .OPCODE_W(OPCODE_W), .CNT_W(4))     bus4 ();

  // Incrementer model: new_pc = old_pc + value, wrapping at LENGTH bits.
  assign bus.new_pc  = bus.old_pc + LENGTH'(bus.value);
  assign bus4.new_pc = bus4.old_pc + LENGTH'(bus4.value);

  pc_fetch_ctrl #(
    .LENGTH(LENGTH), .OPCODE_W(OPCODE_W), .HALT_OPCODE(5'b0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pc_fetch_ctrl #(
    .LENGTH(LENGTH), .OPCODE_W(OPCODE_W), .HALT_OPCODE(5'b0), .CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  always @(posedge clk) begin
    if (bus.value === 1'b1) n_val++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle: one empty FETCH, then ROM answers in the first WAIT cycle.
  task automatic do_op(input logic [OPCODE_W-1:0] op);
    bus.instr_valid = 1'b0;
    tick();
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    #1;
    chk("value_in_wait", bus.value, (op != 0));
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.opcode       = '0;
    bus4.start       = 1'b0;
    bus4.instr_valid = 1'b0;
    bus4.opcode      = '0;
`ifdef PC_STEP_EN
    bus.step_mode    = 1'b0;
    bus.step         = 1'b0;
    bus4.step_mode   = 1'b0;
    bus4.step        = 1'b0;
`endif
    tick();
    tick();
    chk("rst_old_pc", bus.old_pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_fetch_req", bus.fetch_req, 0);
    chk("rst_cycle_count", bus.cycle_count, 0);
    chk("rst_value", bus.value, 0);
    rst = 1'b0;
    tick();

    // instr_valid while IDLE is ignored
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'd1;
    tick();
    tick();
    bus.instr_valid = 1'b0;
    chk("idle_valid_pc", bus.old_pc, 0);
    chk("idle_valid_busy", bus.busy, 0);

    // async reset in the middle of WAIT with old_pc=5
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_fetch_req", bus.fetch_req, 1);
    for (int i = 0; i < 5; i++) do_op(5'd1);
    chk("t1_pc5", bus.old_pc, 5);
    tick();
    chk("t1_in_wait_busy", bus.busy, 1);
    chk("t1_in_wait_fetch", bus.fetch_req, 0);
    rst = 1'b1;
    #1;
    chk("t1_async_pc", bus.old_pc, 0);
    chk("t1_async_busy", bus.busy, 0);
    chk("t1_async_fetch", bus.fetch_req, 0);
    chk("t1_async_halted", bus.halted, 0);
    chk("t1_async_cnt", bus.cycle_count, 0);
    chk("t1_async_value", bus.value, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle_after", bus.busy, 0);

    // short program 01,02,03,00
    n_val     = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t2_pc0", bus.old_pc, 0);
    chk("t2_fetch0", bus.fetch_req, 1);
    chk("t2_cnt0", bus.cycle_count, 0);
    do_op(5'd1);
    chk("t2_pc1", bus.old_pc, 1);
    chk("t2_cnt2", bus.cycle_count, 2);
    do_op(5'd2);
    chk("t2_pc2", bus.old_pc, 2);
    do_op(5'd3);
    chk("t2_pc3", bus.old_pc, 3);
    chk("t2_fetch3", bus.fetch_req, 1);
    do_op(5'd0);
    chk("t2_halted", bus.halted, 1);
    chk("t2_halt_pc", bus.old_pc, 3);
    chk("t2_halt_cnt", bus.cycle_count, 8);
    chk("t2_halt_busy", bus.busy, 0);
    chk("t2_halt_fetch", bus.fetch_req, 0);
    chk("t2_value_pulses", n_val, 3);

    // ignored inputs, restart from HALT, start+instr_valid collision in WAIT
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'd1;
    tick();
    bus.instr_valid = 1'b0;
    chk("t5_halt_valid_pc", bus.old_pc, 3);
    chk("t5_halt_valid_halted", bus.halted, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_restart_pc", bus.old_pc, 0);
    chk("t5_restart_cnt", bus.cycle_count, 0);
    chk("t5_restart_fetch", bus.fetch_req, 1);
    chk("t5_restart_halted", bus.halted, 0);
    bus.start = 1'b1;
    tick();
    chk("t5_start_fetch_fr", bus.fetch_req, 0);
    chk("t5_start_fetch_cnt", bus.cycle_count, 1);
    tick();
    bus.start = 1'b0;
    chk("t5_start_wait_busy", bus.busy, 1);
    chk("t5_start_wait_fr", bus.fetch_req, 0);
    chk("t5_start_wait_cnt", bus.cycle_count, 2);
    chk("t5_start_wait_pc", bus.old_pc, 0);
    bus.start       = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'd5;
    tick();
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    chk("t5_collide_pc", bus.old_pc, 1);
    chk("t5_collide_fetch", bus.fetch_req, 1);
    chk("t5_collide_cnt", bus.cycle_count, 3);

    // PC wrap at all-ones
    for (int i = 0; i < 2046; i++) do_op(5'd1);
    chk("t3_pc_max", bus.old_pc, 32'h7FF);
    chk("t3_cnt_max", bus.cycle_count, 4095);
    do_op(5'd1);
    chk("t3_pc_wrap", bus.old_pc, 0);
    chk("t3_busy_wrap", bus.busy, 1);
    chk("t3_fetch_wrap", bus.fetch_req, 1);
    chk("t3_cnt_wrap", bus.cycle_count, 4097);

`ifdef PC_STEP_EN
    // single-step hold and release
    bus.step_mode = 1'b1;
    do_op(5'd1);
    chk("t6_step_pc", bus.old_pc, 1);
    chk("t6_step_busy", bus.busy, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t6_no_fetch", bus.fetch_req, 0);
      tick();
    end
    chk("t6_cnt_frozen", bus.cycle_count, 4099);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("t6_step_fetch", bus.fetch_req, 1);
    chk("t6_step_cnt", bus.cycle_count, 4099);
    do_op(5'd1);
    chk("t6_step2_fetch", bus.fetch_req, 0);
    bus.step_mode = 1'b0;
    tick();
    chk("t6_mode_off_fetch", bus.fetch_req, 1);
    chk("t6_mode_off_cnt", bus.cycle_count, 4101);
    chk("t6_mode_off_pc", bus.old_pc, 2);
`endif

    // 4-bit counter saturation while stalled in WAIT
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    chk("t4_fetch", bus4.fetch_req, 1);
    chk("t4_cnt0", bus4.cycle_count, 0);
    tick();
    chk("t4_cnt1", bus4.cycle_count, 1);
    repeat (13) tick();
    chk("t4_cnt14", bus4.cycle_count, 14);
    repeat (7) tick();
    chk("t4_cnt_sat", bus4.cycle_count, 15);
    chk("t4_busy", bus4.busy, 1);
    chk("t4_pc", bus4.old_pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
